// File: rtl/menu_overlay_pkg.sv
// Shared types, palette and geometry helpers for the start-menu overlay.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package menu_overlay_pkg;

  localparam int COLOR_W = 12;
  localparam int COORD_W = 11;

  typedef logic [COLOR_W-1:0] color_t;

  // Palette; NULL marks a transparent overlay pixel for the downstream colour mux.
  localparam color_t NULL         = 12'h000;
  localparam color_t CURSOR_COLOR = 12'hFF0;
  localparam color_t OPT_PAL0     = 12'hF00;
  localparam color_t OPT_PAL1     = 12'h0F0;
  localparam color_t OPT_PAL2     = 12'h00F;
  localparam color_t OPT_PAL3     = 12'hFFF;
  localparam color_t LIMITED      = 12'h888;
  localparam color_t CONTEST      = 12'h0FF;

  // First pipeline stage: offsets relative to the icon origins of the hit row.
  typedef struct packed {
    logic [COORD_W-1:0] dx_c;
    logic [COORD_W-1:0] dx_s;
    logic [COORD_W-1:0] dy;
    logic [3:0]         r;
    logic               r_vld;
  } s1_t;

  // Option value to swatch colour.
  function automatic color_t opt_pal(input logic [1:0] v);
    case (v)
      2'd0:    return OPT_PAL0;
      2'd1:    return OPT_PAL1;
      2'd2:    return OPT_PAL2;
      default: return OPT_PAL3;
    endcase
  endfunction

  // Pixel lies on one of the two arms of the cursor chevron (2-pixel tolerance).
  // Only meaningful when dx, dy are already known to be inside the icon.
  function automatic logic on_diag(input logic [COORD_W-1:0] dx,
                                   input logic [COORD_W-1:0] dy,
                                   input int icon);
    int d1;
    int d2;
    d1 = int'(dx) - 2 * int'(dy);
    d2 = int'(dx) - 2 * (icon - 1 - int'(dy));
    return (d1 >= -2 && d1 <= 2) || (d2 >= -2 && d2 <= 2);
  endfunction

endpackage

// File: rtl/menu_overlay_btn_edge.sv
// Rising-edge detector for one debounced button level.
// Latency: pulse is combinational from btn against last cycle's registered level.
// Backpressure: none; a held level yields exactly one pulse.
module menu_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic btn_q;

  // Remember last cycle's level so only the 0->1 transition pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn;
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/menu_overlay.sv
// Start-menu overlay: cursor/option state from buttons plus a 2-stage pixel colour pipeline.
// Latency: color is 2 cycles after col_addr/row_addr; state updates on the clock after a button edge.
// Backpressure: none; pixel stream runs every cycle, buttons are level inputs sampled each cycle.
module menu_overlay
  import menu_overlay_pkg::*;
#(
  parameter int N_ITEMS    = 3,
  parameter int VAL_MAX    = 3,
  parameter int ORIGIN_X   = 274,
  parameter int ORIGIN_Y   = 204,
  parameter int ROW_PITCH  = 50,
  parameter int COL_PITCH  = 60,
  parameter int ICON       = 31,
  parameter int BLINK_BITS = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [9:0]             col_addr,
  input  logic [8:0]             row_addr,
  input  logic                   menu_en,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_sel,
  output logic [2:0]             cursor,
  output logic [2*N_ITEMS-1:0]   opt_vals,
  output logic [11:0]            color
);

  logic up_rise, dn_rise, sel_rise;
  logic up_e, dn_e, sel_e;

  logic [2:0]              cursor_q, cursor_n;
  logic [N_ITEMS-1:0][1:0] vals_q, vals_n;
  logic [BLINK_BITS-1:0]   blink_q, blink_n;

  logic [COORD_W-1:0] row_off;
  logic [COORD_W-1:0] dy_sel;
  logic [3:0]         r_sel;
  s1_t                s1_n, s1_q;

  logic   cur_hit, sw_hit;
  logic [1:0] sw_val;
  color_t color_n;

  menu_btn_edge u_up  (.clk(clk), .rst(rst), .btn(btn_up),   .rise(up_rise));
  menu_btn_edge u_dn  (.clk(clk), .rst(rst), .btn(btn_down), .rise(dn_rise));
  menu_btn_edge u_sel (.clk(clk), .rst(rst), .btn(btn_sel),  .rise(sel_rise));

  // Buttons only act while the menu is shown; edge registers keep tracking regardless.
  assign up_e  = up_rise  & menu_en;
  assign dn_e  = dn_rise  & menu_en;
  assign sel_e = sel_rise & menu_en;

  // Cursor saturates at both ends; select steps the row under the pre-move cursor.
  always_comb begin
    cursor_n = cursor_q;
    vals_n   = vals_q;
    if (up_e && !dn_e && cursor_q != 3'd0)
      cursor_n = cursor_q - 3'd1;
    else if (dn_e && !up_e && cursor_q != 3'(N_ITEMS - 1))
      cursor_n = cursor_q + 3'd1;
    if (sel_e) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        if (cursor_q == 3'(i))
          vals_n[i] = (vals_q[i] == 2'(VAL_MAX - 1)) ? 2'd0 : vals_q[i] + 2'd1;
      end
    end
    // Restart the blink phase on a move so the cursor shows up immediately.
    blink_n = (cursor_n != cursor_q) ? '0 : blink_q + BLINK_BITS'(1);
  end

  // Menu state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor_q <= '0;
      vals_q   <= '0;
      blink_q  <= '0;
    end else begin
      cursor_q <= cursor_n;
      vals_q   <= vals_n;
      blink_q  <= blink_n;
    end
  end

  // Stage 1: row index by comparing against each row start; rows below origin wrap large -> invalid.
  always_comb begin
    row_off = {2'b00, row_addr} - COORD_W'(ORIGIN_Y);
    r_sel   = '0;
    dy_sel  = row_off;
    for (int i = 1; i <= N_ITEMS; i++) begin
      if (row_off >= COORD_W'(i * ROW_PITCH)) begin
        r_sel  = 4'(i);
        dy_sel = row_off - COORD_W'(i * ROW_PITCH);
      end
    end
    s1_n       = '0;
    s1_n.dx_c  = {1'b0, col_addr} - COORD_W'(ORIGIN_X);
    s1_n.dx_s  = {1'b0, col_addr} - COORD_W'(ORIGIN_X + COL_PITCH);
    s1_n.dy    = dy_sel;
    s1_n.r     = r_sel;
    s1_n.r_vld = (r_sel < 4'(N_ITEMS));
  end

  // Stage 1 register; reset clears r_vld so the first colours after release are NULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1_q <= '0;
    else     s1_q <= s1_n;
  end

  // Stage 2 select: cursor has priority over the swatch; menu_en masks everything.
  always_comb begin
    sw_val = 2'd0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (s1_q.r == 4'(i)) sw_val = vals_q[i];
    end
    cur_hit = s1_q.r_vld && (s1_q.r == {1'b0, cursor_q}) && !blink_q[BLINK_BITS-1]
              && (s1_q.dx_c < COORD_W'(ICON)) && (s1_q.dy < COORD_W'(ICON))
              && on_diag(s1_q.dx_c, s1_q.dy, ICON);
    sw_hit  = s1_q.r_vld && (s1_q.dx_s < COORD_W'(ICON)) && (s1_q.dy < COORD_W'(ICON));
    color_n = NULL;
    if (menu_en) begin
      if (cur_hit)     color_n = CURSOR_COLOR;
      else if (sw_hit) color_n = opt_pal(sw_val);
    end
  end

  // Stage 2 register drives the pixel output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) color <= NULL;
    else     color <= color_n;
  end

  assign cursor   = cursor_q;
  assign opt_vals = vals_q;

endmodule

// File: tb/tb_menu_overlay.sv
module tb_menu_overlay;

  localparam int N  = 3;
  localparam int VM = 3;
  localparam int OX = 274;
  localparam int OY = 204;
  localparam int RP = 50;
  localparam int CP = 60;
  localparam int IC = 31;
  localparam int BB = 4;

  localparam logic [11:0] NULL_C = 12'h000;
  localparam logic [11:0] CUR_C  = 12'hFF0;
  localparam logic [11:0] PAL0   = 12'hF00;
  localparam logic [11:0] PAL1   = 12'h0F0;
  localparam logic [11:0] PAL2   = 12'h00F;
  localparam logic [11:0] PAL3   = 12'hFFF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [9:0]   col_addr = '0;
  logic [8:0]   row_addr = '0;
  logic         menu_en = 1'b0;
  logic         btn_up = 1'b0;
  logic         btn_down = 1'b0;
  logic         btn_sel = 1'b0;
  logic [2:0]   cursor;
  logic [2*N-1:0] opt_vals;
  logic [11:0]  color;

  menu_overlay #(
    .N_ITEMS(N), .VAL_MAX(VM), .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .ROW_PITCH(RP), .COL_PITCH(CP), .ICON(IC), .BLINK_BITS(BB)
  ) dut (
    .clk(clk), .rst(rst), .col_addr(col_addr), .row_addr(row_addr),
    .menu_en(menu_en), .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .cursor(cursor), .opt_vals(opt_vals), .color(color)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [11:0]    color;
    logic [2:0]     cursor;
    logic [2*N-1:0] vals;
  } exp_t;
  exp_t q[$];

  // Reference model state: menu contents, cycles since last move, previous button levels.
  int m_cur;
  int m_vals[N];
  int m_age;
  bit m_pu, m_pd, m_ps;
  bit m_pv;
  int m_pcol, m_prow;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [11:0] pal(input int v);
    case (v)
      0: return PAL0;
      1: return PAL1;
      2: return PAL2;
      default: return PAL3;
    endcase
  endfunction

  // Geometric definition of the overlay picture.
  function automatic logic [11:0] ref_color(input int col, input int row, input int cur, input bit vis);
    for (int r = 0; r < N; r++) begin
      int y0 = OY + r * RP;
      int dy = row - y0;
      int dx = col - OX;
      int ds = col - OX - CP;
      if (dy >= 0 && dy < IC) begin
        if (r == cur && vis && dx >= 0 && dx < IC &&
            (iabs(dx - 2 * dy) <= 2 || iabs(dx - 2 * (IC - 1 - dy)) <= 2))
          return CUR_C;
        if (ds >= 0 && ds < IC) return pal(m_vals[r]);
      end
    end
    return NULL_C;
  endfunction

  function automatic logic [2*N-1:0] pack_vals();
    logic [2*N-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[2*i +: 2] = 2'(m_vals[i]);
    return p;
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show after the next rising edge.
  task automatic step(input bit up, input bit dn, input bit sel, input bit en,
                      input int col, input int row, input bit r);
    exp_t e;
    bit ue, de, se;
    int old;
    @(negedge clk);
    rst = r; btn_up = up; btn_down = dn; btn_sel = sel; menu_en = en;
    col_addr = 10'(col); row_addr = 9'(row);
    if (r) begin
      m_cur = 0; m_age = 0; m_pu = 0; m_pd = 0; m_ps = 0; m_pv = 0;
      for (int i = 0; i < N; i++) m_vals[i] = 0;
      e.color = NULL_C;
    end else begin
      e.color = (en && m_pv) ? ref_color(m_pcol, m_prow, m_cur, m_age < (1 << (BB - 1))) : NULL_C;
      ue = up && !m_pu && en;
      de = dn && !m_pd && en;
      se = sel && !m_ps && en;
      old = m_cur;
      if (ue && !de && m_cur > 0) m_cur = m_cur - 1;
      if (de && !ue && m_cur < N - 1) m_cur = m_cur + 1;
      if (se) m_vals[old] = (m_vals[old] + 1) % VM;
      m_age = (m_cur != old) ? 0 : (m_age + 1) % (1 << BB);
      m_pu = up; m_pd = dn; m_ps = sel;
      m_pv = 1; m_pcol = col; m_prow = row;
    end
    e.cursor = 3'(m_cur);
    e.vals = pack_vals();
    q.push_back(e);
  endtask

  task automatic press(input bit up, input bit dn, input bit sel, input bit en);
    step(up, dn, sel, en, 0, 0, 0);
    step(0, 0, 0, en, 0, 0, 0);
  endtask

  // Scoreboard monitor: compare every cycle that has a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_color", 32'(color), 32'(e.color));
        check("sb_cursor", 32'(cursor), 32'(e.cursor));
        check("sb_opt_vals", 32'(opt_vals), 32'(e.vals));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int vis_cnt;
    // 1: reset values
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #2;
    check("reset_color", 32'(color), 32'(NULL_C));
    check("reset_cursor", 32'(cursor), 32'd0);
    check("reset_vals", 32'(opt_vals), 32'd0);

    // 2: navigation
    press(0, 1, 0, 1); @(posedge clk); #2; check("nav_down1", 32'(cursor), 32'd1);
    press(0, 1, 0, 1); @(posedge clk); #2; check("nav_down2", 32'(cursor), 32'd2);
    press(0, 1, 0, 1); @(posedge clk); #2; check("nav_down3", 32'(cursor), 32'd2);
    press(1, 0, 0, 1); @(posedge clk); #2; check("nav_up1", 32'(cursor), 32'd1);
    press(1, 0, 0, 1); @(posedge clk); #2; check("nav_up2", 32'(cursor), 32'd0);
    press(1, 0, 0, 1); @(posedge clk); #2; check("nav_up3", 32'(cursor), 32'd0);
    press(0, 1, 0, 1); @(posedge clk); #2; check("nav_to1", 32'(cursor), 32'd1);
    press(1, 1, 0, 1); @(posedge clk); #2; check("nav_updown", 32'(cursor), 32'd1);

    // 3: value wrap on row 1
    press(0, 0, 1, 1); @(posedge clk); #2; check("val_1", 32'(opt_vals), 32'h04);
    press(0, 0, 1, 1); @(posedge clk); #2; check("val_2", 32'(opt_vals), 32'h08);
    press(0, 0, 1, 1); @(posedge clk); #2; check("val_0", 32'(opt_vals), 32'h00);
    press(0, 0, 1, 1); @(posedge clk); #2; check("val_1b", 32'(opt_vals), 32'h04);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #2; check("val_held", 32'(opt_vals), 32'h08);

    // 4: swatch and cursor pixels, two cycles after the address
    step(0, 0, 0, 1, OX + CP + 5, OY + RP + 5, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #2; check("pix_swatch", 32'(color), 32'(PAL2));
    press(1, 0, 0, 1);
    step(0, 0, 0, 1, OX + 10, OY + 5, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #2; check("pix_cursor", 32'(color), 32'(CUR_C));

    // 5: blink duty over two full periods, then enable masking
    step(0, 0, 0, 1, OX + 10, OY + 5, 0);
    step(0, 0, 0, 1, OX + 10, OY + 5, 0);
    vis_cnt = 0;
    for (int i = 0; i < 2 * (1 << BB); i++) begin
      step(0, 0, 0, 1, OX + 10, OY + 5, 0);
      @(posedge clk); #2;
      if (color == CUR_C) vis_cnt++;
    end
    check("blink_duty", 32'(vis_cnt), 32'(1 << BB));
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, OX + 10, OY + RP + 5, 0);
    press(0, 1, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, OX + 10, OY + RP + 5, 0);
    step(0, 1, 0, 0, OX + 10, OY + RP + 5, 0);
    step(0, 0, 1, 0, OX + CP + 5, OY + RP + 5, 0);
    step(0, 0, 0, 0, OX + CP + 5, OY + RP + 5, 0);
    @(posedge clk); #2;
    check("dis_color", 32'(color), 32'(NULL_C));
    check("dis_cursor", 32'(cursor), 32'd1);
    check("dis_vals", 32'(opt_vals), 32'h08);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, OX + CP + 5, OY + RP + 5, 0);

    // 6: bounds
    step(0, 0, 0, 1, OX - 1, OY + 5, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #2; check("bnd_left", 32'(color), 32'(NULL_C));
    step(0, 0, 0, 1, OX + CP + 5, OY + N * RP, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #2; check("bnd_below", 32'(color), 32'(NULL_C));
    step(0, 0, 0, 1, OX + CP + 5, OY + IC + 2, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #2; check("bnd_gap", 32'(color), 32'(NULL_C));

    // 1b: asynchronous reset mid-frame on a lit swatch
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, OX + CP + 5, OY + RP + 5, 0);
    @(negedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_color", 32'(color), 32'(NULL_C));
    check("arst_cursor", 32'(cursor), 32'd0);
    check("arst_vals", 32'(opt_vals), 32'd0);
    step(0, 0, 0, 1, OX + CP + 5, OY + 5, 1);
    step(0, 0, 0, 1, OX + CP + 5, OY + 5, 0);
    @(posedge clk); #2; check("arst_lat1", 32'(color), 32'(NULL_C));
    step(0, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #2; check("arst_lat2", 32'(color), 32'(PAL0));

    // Randomised traffic around the menu area
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 15) != 0,
           OX - 5 + int'($urandom_range(0, CP + IC + 10)),
           OY - 5 + int'($urandom_range(0, N * RP + 10)),
           $urandom_range(0, 499) == 0);
    end
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #3;
    check("sb_drain", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
